// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - instruction/data request ports and shared SRAM pins of the arbiter
interface sram_arbiter_if;
  // instruction fetch port
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  // data port
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_bweb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  // shared synchronous SRAM
  logic        sram_ceb;
  logic        sram_web;
  logic [31:0] sram_bweb;
  logic [13:0] sram_a;
  logic [31:0] sram_di;
  logic [31:0] sram_do;

  // arbiter side
  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_bweb,
    output d_gnt, d_rvalid, d_rdata,
    output sram_ceb, sram_web, sram_bweb, sram_a, sram_di,
    input  sram_do
  );

  // requester side (both ports)
  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_bweb,
    input  d_gnt, d_rvalid, d_rdata
  );

  // memory side
  modport mem (
    input  sram_ceb, sram_web, sram_bweb, sram_a, sram_di,
    output sram_do
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter in front of one synchronous SRAM with starvation guard
module sram_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);

  // counter holds 0..STARVE_LIMIT
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  // access issued in the previous cycle; decides who owns sram_do now
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2,
    WR   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            i_win;
  logic            d_win;
  logic            starved;

  // byte-lane bits of the addresses never reach the word-addressed SRAM
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  assign starved = (starve_cnt_q == LIMIT_C);

  // combinational grant: data preferred unless the instruction port has waited too long;
  // held off entirely while reset is asserted
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (rst) begin
      if (bus.i_req && (!bus.d_req || starved)) begin
        i_win = 1'b1;
      end else if (bus.d_req) begin
        d_win = 1'b1;
      end
    end
  end

  assign bus.i_gnt = i_win;
  assign bus.d_gnt = d_win;

  // drive the SRAM pins from the winning port, idle values otherwise
  always_comb begin
    bus.sram_ceb  = 1'b1;
    bus.sram_web  = 1'b1;
    bus.sram_bweb = '1;
    bus.sram_a    = '0;
    bus.sram_di   = '0;
    if (i_win) begin
      bus.sram_ceb = 1'b0;
      bus.sram_a   = bus.i_addr[15:2];
    end else if (d_win) begin
      bus.sram_ceb  = 1'b0;
      bus.sram_web  = !bus.d_we;
      bus.sram_bweb = bus.d_bweb;
      bus.sram_a    = bus.d_addr[15:2];
      bus.sram_di   = bus.d_wdata;
    end
  end

  // starvation counter: counts consecutive denied instruction cycles, saturating
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.i_req || i_win) begin
      starve_cnt_d = '0;
    end else if (!starved) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // next state records the kind of access launched this cycle
  always_comb begin
    state_d = IDLE;
    if (i_win) begin
      state_d = RD_I;
    end else if (d_win) begin
      state_d = bus.d_we ? WR : RD_D;
    end
  end

  // read response: sram_do belongs to whichever port read last cycle; rdata is zero otherwise
  always_comb begin
    bus.i_rvalid = 1'b0;
    bus.i_rdata  = '0;
    bus.d_rvalid = 1'b0;
    bus.d_rdata  = '0;
    case (state_q)
      RD_I: begin
        bus.i_rvalid = 1'b1;
        bus.i_rdata  = bus.sram_do;
      end
      RD_D: begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = bus.sram_do;
      end
      default: ;
    endcase
  end

  // state and counter registers; reset drops any read in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst;

  sram_arbiter_if bif();

  sram_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // {ceb, web, bweb, a, di, i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata}
  localparam logic [147:0] IDLE_VEC = {1'b1, 1'b1, 32'hFFFF_FFFF, 14'h0, 32'h0, 4'h0, 32'h0, 32'h0};
  logic [147:0] out_vec;
  assign out_vec = {bif.sram_ceb, bif.sram_web, bif.sram_bweb, bif.sram_a, bif.sram_di,
                    bif.i_gnt, bif.d_gnt, bif.i_rvalid, bif.d_rvalid, bif.i_rdata, bif.d_rdata};

  task automatic clear_inputs();
    bif.i_req   = 1'b0;
    bif.i_addr  = 16'h0;
    bif.d_req   = 1'b0;
    bif.d_we    = 1'b0;
    bif.d_addr  = 16'h0;
    bif.d_wdata = 32'h0;
    bif.d_bweb  = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    bif.i_req = 1'b1; bif.i_addr = 16'h0008;
    bif.d_req = 1'b1; bif.d_addr = 16'h0100;
    bif.sram_do = 32'h5555_AAAA;
    #1;
    n_cmp++;
    if (out_vec !== IDLE_VEC) begin
      n_bad++; $display("FAIL reset_outputs got=%h exp=%h", out_vec, IDLE_VEC);
    end
    n_cmp++;
    if (int'(dut.starve_cnt_q) !== 0) begin
      n_bad++; $display("FAIL reset_starve got=%0d exp=0", dut.starve_cnt_q);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_vec !== IDLE_VEC) begin
      n_bad++; $display("FAIL reset_held got=%h exp=%h", out_vec, IDLE_VEC);
    end
    // release with only the instruction port requesting: grant at once
    @(negedge clk);
    rst = 1'b1; bif.d_req = 1'b0;
    #1;
    n_cmp++;
    if ({bif.i_gnt, bif.d_gnt, bif.sram_ceb, bif.sram_a} !== {1'b1, 1'b0, 1'b0, 14'h0002}) begin
      n_bad++; $display("FAIL first_grant got=%b%b%b/%h exp=100/0002", bif.i_gnt, bif.d_gnt, bif.sram_ceb, bif.sram_a);
    end
    @(negedge clk);
    bif.i_req = 1'b0; bif.sram_do = 32'h0BAD_F00D;
    #1;
    n_cmp++;
    if ({bif.i_rvalid, bif.i_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
      n_bad++; $display("FAIL first_rvalid got=%b/%h exp=1/0badf00d", bif.i_rvalid, bif.i_rdata);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (out_vec !== IDLE_VEC) begin
      n_bad++; $display("FAIL after_first got=%h exp=%h", out_vec, IDLE_VEC);
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bif.i_req = 1'b1; bif.i_addr = 16'h0010;
    #1;
    n_cmp++;
    if ({bif.i_gnt, bif.d_gnt, bif.sram_ceb, bif.sram_web, bif.sram_bweb, bif.sram_a}
        !== {1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 14'h0004}) begin
      n_bad++; $display("FAIL single_read_req gnt=%b/%b ceb=%b web=%b bweb=%h a=%h exp 1/0 0 1 ffffffff 0004",
                        bif.i_gnt, bif.d_gnt, bif.sram_ceb, bif.sram_web, bif.sram_bweb, bif.sram_a);
    end
    @(negedge clk);
    bif.i_req = 1'b0; bif.sram_do = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if ({bif.i_rvalid, bif.i_rdata, bif.d_rvalid, bif.d_rdata, bif.sram_ceb}
        !== {1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1}) begin
      n_bad++; $display("FAIL single_read_rsp got=%b/%h %b/%h ceb=%b exp=1/deadbeef 0/00000000 ceb=1",
                        bif.i_rvalid, bif.i_rdata, bif.d_rvalid, bif.d_rdata, bif.sram_ceb);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bif.i_rvalid, bif.i_rdata} !== {1'b0, 32'h0}) begin
      n_bad++; $display("FAIL single_read_end got=%b/%h exp=0/00000000", bif.i_rvalid, bif.i_rdata);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    bif.d_req = 1'b1; bif.d_we = 1'b1; bif.d_addr = 16'h0104;
    bif.d_wdata = 32'h1234_5678; bif.d_bweb = 32'h0000_FFFF;
    #1;
    n_cmp++;
    if ({bif.d_gnt, bif.i_gnt, bif.sram_ceb, bif.sram_web, bif.sram_a, bif.sram_bweb, bif.sram_di}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 14'h0041, 32'h0000_FFFF, 32'h1234_5678}) begin
      n_bad++; $display("FAIL write_req gnt=%b/%b ceb=%b web=%b a=%h bweb=%h di=%h exp 1/0 0 0 0041 0000ffff 12345678",
                        bif.d_gnt, bif.i_gnt, bif.sram_ceb, bif.sram_web, bif.sram_a, bif.sram_bweb, bif.sram_di);
    end
    @(negedge clk);
    clear_inputs(); bif.sram_do = 32'h7777_7777;
    #1;
    n_cmp++;
    if ({bif.d_rvalid, bif.d_rdata, bif.i_rvalid, bif.i_rdata} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL write_no_rvalid got=%b/%h %b/%h exp=0/00000000 0/00000000",
                        bif.d_rvalid, bif.d_rdata, bif.i_rvalid, bif.i_rdata);
    end
  endtask

  task automatic test_conflict();
    for (int k = 0; k < 8; k++) begin
      logic exp_i;
      logic prev_i;
      logic [1:0] exp_rv;
      @(negedge clk);
      bif.i_req = 1'b1; bif.i_addr = 16'h0200;
      bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 16'h0300;
      #1;
      exp_i  = ((k % 4) == 3);
      prev_i = (((k + 3) % 4) == 3);
      exp_rv = (k == 0) ? 2'b00 : {prev_i, !prev_i};
      n_cmp++;
      if ({bif.i_gnt, bif.d_gnt, bif.sram_a} !== {exp_i, !exp_i, exp_i ? 14'h0080 : 14'h00C0}) begin
        n_bad++; $display("FAIL conflict_gnt[%0d] got=%b%b/%h exp=%b%b/%h", k, bif.i_gnt, bif.d_gnt, bif.sram_a,
                          exp_i, !exp_i, exp_i ? 14'h0080 : 14'h00C0);
      end
      n_cmp++;
      if (int'(dut.starve_cnt_q) !== (k % 4)) begin
        n_bad++; $display("FAIL conflict_starve[%0d] got=%0d exp=%0d", k, dut.starve_cnt_q, k % 4);
      end
      n_cmp++;
      if ({bif.i_rvalid, bif.d_rvalid} !== exp_rv) begin
        n_bad++; $display("FAIL conflict_rvalid[%0d] got=%b%b exp=%b", k, bif.i_rvalid, bif.d_rvalid, exp_rv);
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if ({bif.i_rvalid, bif.d_rvalid, dut.starve_cnt_q} !== {1'b1, 1'b0, 2'd0}) begin
      n_bad++; $display("FAIL conflict_end got=%b%b/%0d exp=10/0", bif.i_rvalid, bif.d_rvalid, dut.starve_cnt_q);
    end
  endtask

  task automatic test_drop_request();
    // {i_req, exp d_gnt, exp i_gnt, exp starve count seen this cycle}
    logic [3:0] vec [5];
    vec[0] = {1'b1, 1'b1, 1'b0, 1'b0};
    vec[1] = {1'b1, 1'b1, 1'b0, 1'b0};
    vec[2] = {1'b0, 1'b1, 1'b0, 1'b0};
    vec[3] = {1'b1, 1'b1, 1'b0, 1'b0};
    vec[4] = {1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      int exp_cnt;
      exp_cnt = (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 2 : (k == 3) ? 0 : 1;
      @(negedge clk);
      bif.i_req = vec[k][3]; bif.i_addr = 16'h0040;
      bif.d_req = 1'b1; bif.d_we = 1'b1; bif.d_addr = 16'h0044;
      #1;
      n_cmp++;
      if ({bif.d_gnt, bif.i_gnt} !== vec[k][2:1] || int'(dut.starve_cnt_q) !== exp_cnt) begin
        n_bad++; $display("FAIL drop_req[%0d] gnt=%b%b cnt=%0d exp gnt=%b cnt=%0d", k, bif.d_gnt, bif.i_gnt,
                          dut.starve_cnt_q, vec[k][2:1], exp_cnt);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 16'h0040;
    #1;
    n_cmp++;
    if ({bif.d_gnt, bif.i_gnt, bif.sram_web, bif.sram_a} !== {1'b1, 1'b0, 1'b1, 14'h0010}) begin
      n_bad++; $display("FAIL b2b_c1 got=%b%b web=%b a=%h exp=10 web=1 a=0010", bif.d_gnt, bif.i_gnt, bif.sram_web, bif.sram_a);
    end
    @(negedge clk);
    clear_inputs();
    bif.i_req = 1'b1; bif.i_addr = 16'h0080; bif.sram_do = 32'hAAAA_0001;
    #1;
    n_cmp++;
    if ({bif.d_rvalid, bif.d_rdata, bif.i_rvalid, bif.i_rdata, bif.i_gnt, bif.sram_a}
        !== {1'b1, 32'hAAAA_0001, 1'b0, 32'h0, 1'b1, 14'h0020}) begin
      n_bad++; $display("FAIL b2b_c2 d=%b/%h i=%b/%h gnt=%b a=%h exp d=1/aaaa0001 i=0/00000000 gnt=1 a=0020",
                        bif.d_rvalid, bif.d_rdata, bif.i_rvalid, bif.i_rdata, bif.i_gnt, bif.sram_a);
    end
    @(negedge clk);
    bif.i_req = 1'b0; bif.sram_do = 32'hBBBB_0002;
    #1;
    n_cmp++;
    if ({bif.i_rvalid, bif.i_rdata, bif.d_rvalid, bif.d_rdata} !== {1'b1, 32'hBBBB_0002, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL b2b_c3 i=%b/%h d=%b/%h exp i=1/bbbb0002 d=0/00000000",
                        bif.i_rvalid, bif.i_rdata, bif.d_rvalid, bif.d_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    bif.i_req = 1'b1; bif.i_addr = 16'h0400;
    #1;
    n_cmp++;
    if (bif.i_gnt !== 1'b1) begin
      n_bad++; $display("FAIL midrst_gnt got=%b exp=1", bif.i_gnt);
    end
    @(posedge clk); #1;
    bif.i_req = 1'b0; bif.sram_do = 32'hCAFE_F00D;
    #1;
    n_cmp++;
    if (bif.i_rvalid !== 1'b1) begin
      n_bad++; $display("FAIL midrst_pending got=%b exp=1", bif.i_rvalid);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (out_vec !== IDLE_VEC) begin
      n_bad++; $display("FAIL midrst_immediate got=%h exp=%h", out_vec, IDLE_VEC);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (out_vec !== IDLE_VEC) begin
        n_bad++; $display("FAIL midrst_after[%0d] got=%h exp=%h", k, out_vec, IDLE_VEC);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_idle();
    clear_inputs();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bif.sram_do = 32'h1000_0000 + 32'(k);
      #1;
      n_cmp++;
      if (out_vec !== IDLE_VEC || int'(dut.starve_cnt_q) !== 0) begin
        n_bad++; $display("FAIL idle[%0d] got=%h cnt=%0d exp=%h cnt=0", k, out_vec, dut.starve_cnt_q, IDLE_VEC);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bif.sram_do = 32'h0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write();
    test_conflict();
    test_drop_request();
    test_back_to_back();
    test_reset_mid_read();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
